// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with exact occupancy, threshold flags, sticky error flags and flush.
// Optional first-word-fall-through read path is compiled in with SYNC_FIFO_FWFT_EN.
module sync_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  ffull,
  output logic                  fempty,
  output logic                  fafull,
  output logic                  faempty,
  output logic [ADDR_WIDTH:0]   fifo_count,
  output logic                  wack,
  output logic                  rack,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;

  // Flags decode the registered count only, so they settle with the count itself.
  assign ffull   = (fifo_count == DEPTH_C);
  assign fempty  = (fifo_count == '0);
  assign fafull  = (fifo_count >= AFULL_C);
  assign faempty = (fifo_count <= AEMPTY_C);

  assign rd_ok = rd & ~fempty;
  assign wr_ok = we & (~ffull | rd_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wack       <= 1'b0;
      rack       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      wack       <= 1'b0;
      rack       <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wack <= wr_ok;
      rack <= rd_ok;
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_ok && !rd_ok)      fifo_count <= fifo_count + CNT_ONE;
      else if (rd_ok && !wr_ok) fifo_count <= fifo_count - CNT_ONE;
      if (we && !wr_ok) overflow  <= 1'b1;
      if (rd && fempty) underflow <= 1'b1;
    end
  end

  // Storage is not reset; the count alone decides which words are valid.
  always_ff @(posedge clk) begin
    if (wr_ok && !clr) mem[wr_ptr] <= data;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign q = mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                q <= '0;
    else if (rd_ok && !clr) q <= mem[rd_ptr];
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed plus randomized stimulus for sync_fifo, checked against a queue-based model.
module tb_sync_fifo;
  localparam int DW     = 8;
  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int AFULL  = 12;
  localparam int AEMPTY = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          we  = 1'b0;
  logic [DW-1:0] data = '0;
  logic          rd  = 1'b0;
  logic [DW-1:0] q;
  logic          ffull, fempty, fafull, faempty;
  logic [AW:0]   fifo_count;
  logic          wack, rack, overflow, underflow;

  sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_LEVEL(AFULL), .AEMPTY_LEVEL(AEMPTY)) dut (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .data(data), .rd(rd), .q(q),
    .ffull(ffull), .fempty(fempty), .fafull(fafull), .faempty(faempty),
    .fifo_count(fifo_count), .wack(wack), .rack(rack),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] q_m;
  logic          wack_m, rack_m, ovf_m, unf_m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".count"},   32'(fifo_count), 32'(sz));
    check({tag, ".ffull"},   32'(ffull),      32'(sz == DEPTH));
    check({tag, ".fempty"},  32'(fempty),     32'(sz == 0));
    check({tag, ".fafull"},  32'(fafull),     32'(sz >= AFULL));
    check({tag, ".faempty"}, 32'(faempty),    32'(sz <= AEMPTY));
    check({tag, ".wack"},    32'(wack),       32'(wack_m));
    check({tag, ".rack"},    32'(rack),       32'(rack_m));
    check({tag, ".ovf"},     32'(overflow),   32'(ovf_m));
    check({tag, ".unf"},     32'(underflow),  32'(unf_m));
`ifdef SYNC_FIFO_FWFT_EN
    if (sz > 0) check({tag, ".q"}, 32'(q), 32'(mq[0]));
`else
    check({tag, ".q"}, 32'(q), 32'(q_m));
`endif
  endtask

  task automatic model_reset();
    mq.delete();
    q_m = '0; wack_m = 0; rack_m = 0; ovf_m = 0; unf_m = 0;
  endtask

  // One clock: apply inputs, advance model on the edge, check 1 time unit later.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c,
                       input string tag);
    bit full, empty, rok, wok;
    we = w; data = d; rd = r; clr = c;
    @(posedge clk);
    if (c) begin
      mq.delete();
      wack_m = 0; rack_m = 0; ovf_m = 0; unf_m = 0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      rok   = r && !empty;
      wok   = w && (!full || rok);
      if (r && empty) unf_m = 1;
      if (w && !wok)  ovf_m = 1;
      if (rok) q_m = mq.pop_front();
      if (wok) mq.push_back(d);
      wack_m = wok;
      rack_m = rok;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] dv;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fill 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0, "fill");
    check("full_count", 32'(fifo_count), 32'd16);
    // Write while full is dropped
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, "ovf");
    check("ovf_set", 32'(overflow), 32'd1);
    // Drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "drain");
    check("drained_empty", 32'(fempty), 32'd1);

    // Read on empty with simultaneous write: refused read, accepted write
    cycle(1'b1, 8'h55, 1'b1, 1'b0, "unf");
    check("unf_rack", 32'(rack), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "unf_pop");
`ifndef SYNC_FIFO_FWFT_EN
    check("unf_pop_q", 32'(q), 32'h55);
`endif

    // Fill then sustained read+write at full across pointer wrap
    dv = 8'h20;
    for (int i = 0; i < DEPTH; i++) begin cycle(1'b1, dv, 1'b0, 1'b0, "refill"); dv++; end
    for (int i = 0; i < 40; i++) begin cycle(1'b1, dv, 1'b1, 1'b0, "stream"); dv++; end
    check("stream_count", 32'(fifo_count), 32'd16);

    // Flush with we/rd active
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "pre_clr");
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "shrink");
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, "clr");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "post_clr_unf");
    cycle(1'b0, 8'h00, 1'b0, 1'b1, "clr2");

    // FWFT / single word path
    cycle(1'b1, 8'h3C, 1'b0, 1'b0, "one_wr");
    cycle(1'b0, 8'h00, 1'b0, 1'b0, "one_idle");
    cycle(1'b0, 8'h00, 1'b1, 1'b0, "one_pop");

    // Randomized traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0, "rand");
    end
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 3) != 0, DW'($urandom), ($urandom % 4) == 0, 1'b0, "rand_hi");
    end

    // Asynchronous reset mid-operation
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h90 + i), 1'b0, 1'b0, "after_rst");
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, "after_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
